// File: rtl/dsack_responder.sv
// Slave-side 68030 bus cycle terminator: drives device strobes and ends the
// cycle with DSACK after a programmed wait count, releasing cleanly on bus error.
module dsack_responder #(
    parameter logic [3:0] WAIT_RD   = 4'd2,
    parameter logic [3:0] WAIT_WR   = 4'd3,
    parameter logic [1:0] PORT_SIZE = 2'b00
) (
    input  logic       sysClk,
    input  logic       nReset,
    input  logic       nAS,
    input  logic       nDS,
    input  logic       sel,
    input  logic       rnw,
    input  logic       nExtWait,
    input  logic       nBerr,
    output logic [1:0] nDsack,
    output logic       nCE,
    output logic       nOE,
    output logic       nWE,
    output logic       busy
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ACCESS  = 2'd1,
        S_ACK     = 2'd2,
        S_RELEASE = 2'd3
    } state_t;

    state_t      r_state;
    logic [3:0]  r_cnt;
    logic        r_rnw;
    logic [1:0]  r_nDsack;
    logic        r_nCE;
    logic        r_nOE;
    logic        r_nWE;
    logic        r_busy;

    state_t      w_state_nx;
    logic [3:0]  w_cnt_nx;
    logic        w_rnw_nx;
    logic [1:0]  w_nDsack_nx;
    logic        w_nCE_nx;
    logic        w_nOE_nx;
    logic        w_nWE_nx;

    always_ff @(posedge sysClk or negedge nReset) begin
        if (!nReset) begin
            r_state  <= S_IDLE;
            r_cnt    <= 4'd0;
            r_rnw    <= 1'b1;
            r_nDsack <= 2'b11;
            r_nCE    <= 1'b1;
            r_nOE    <= 1'b1;
            r_nWE    <= 1'b1;
            r_busy   <= 1'b0;
        end else begin
            r_state  <= w_state_nx;
            r_cnt    <= w_cnt_nx;
            r_rnw    <= w_rnw_nx;
            r_nDsack <= w_nDsack_nx;
            r_nCE    <= w_nCE_nx;
            r_nOE    <= w_nOE_nx;
            r_nWE    <= w_nWE_nx;
            r_busy   <= (w_state_nx != S_IDLE);
        end
    end

    always_comb begin
        w_state_nx  = r_state;
        w_cnt_nx    = r_cnt;
        w_rnw_nx    = r_rnw;
        w_nDsack_nx = r_nDsack;
        w_nCE_nx    = r_nCE;
        w_nOE_nx    = r_nOE;
        w_nWE_nx    = r_nWE;

        unique case (r_state)
            S_IDLE: begin
                w_nDsack_nx = 2'b11;
                w_nCE_nx    = 1'b1;
                w_nOE_nx    = 1'b1;
                w_nWE_nx    = 1'b1;
                if (!nAS && sel) begin
                    // Direction is frozen here; later rnw/sel changes are ignored.
                    w_state_nx = S_ACCESS;
                    w_cnt_nx   = rnw ? WAIT_RD : WAIT_WR;
                    w_rnw_nx   = rnw;
                    w_nCE_nx   = 1'b0;
                    w_nOE_nx   = !rnw;
                end
            end
            S_ACCESS: begin
                if (nAS || !nBerr) begin
                    w_state_nx  = nAS ? S_IDLE : S_RELEASE;
                    w_nDsack_nx = 2'b11;
                    w_nCE_nx    = 1'b1;
                    w_nOE_nx    = 1'b1;
                    w_nWE_nx    = 1'b1;
                end else begin
                    if (!r_rnw && !nDS) begin
                        w_nWE_nx = 1'b0;
                    end
                    if (r_cnt != 4'd0) begin
                        w_cnt_nx = r_cnt - 4'd1;
                    end else if (nExtWait) begin
                        w_state_nx  = S_ACK;
                        w_nDsack_nx = PORT_SIZE;
                    end
                end
            end
            S_ACK: begin
                // Cycle already terminated: only nAS high ends it, nBerr is ignored.
                if (nAS) begin
                    w_state_nx  = S_IDLE;
                    w_nDsack_nx = 2'b11;
                    w_nCE_nx    = 1'b1;
                    w_nOE_nx    = 1'b1;
                    w_nWE_nx    = 1'b1;
                end
            end
            S_RELEASE: begin
                w_nDsack_nx = 2'b11;
                w_nCE_nx    = 1'b1;
                w_nOE_nx    = 1'b1;
                w_nWE_nx    = 1'b1;
                if (nAS) begin
                    w_state_nx = S_IDLE;
                end
            end
            default: begin
                w_state_nx = S_IDLE;
            end
        endcase
    end

    assign nDsack = r_nDsack;
    assign nCE    = r_nCE;
    assign nOE    = r_nOE;
    assign nWE    = r_nWE;
    assign busy   = r_busy;

endmodule
